// File: rtl/controle_sessao.sv
// Ballot-terminal session controller: admits one voter, collects a two-digit code,
// commits one vote into saturating tallies. Define BRANCO_EN to add blank voting.
module controle_sessao #(
  parameter int CNT_W         = 8,
  parameter int TIMEOUT_CYC   = 1000,
  parameter int MAX_ELEITORES = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             libera,
  input  logic [3:0]       digit,
  input  logic             valid,
  input  logic             confirma,
  input  logic             corrige,
  input  logic             swap,
  input  logic             encerra,
`ifdef BRANCO_EN
  input  logic             branco,
  output logic [CNT_W-1:0] contadorBranco,
`endif
  output logic             livre,
  output logic             votando,
  output logic             vote_status,
  output logic             vote_done,
  output logic             encerrada,
  output logic [CNT_W-1:0] contadorC1,
  output logic [CNT_W-1:0] contadorC2,
  output logic [CNT_W-1:0] contadorNull,
  output logic [CNT_W-1:0] total_eleitores
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_VOTOS  = CNT_W'(MAX_ELEITORES);

  typedef enum logic [2:0] {
    OCIOSO,
    DIG1,
    DIG2,
    CONFIRMA,
    GRAVA,
    FIM
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       d1_q, d1_d, d2_q, d2_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             nulo_q, nulo_d;
  logic             pend_q, pend_d;
  logic             status_q, status_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] c1_q, c1_d, c2_q, c2_d, cn_q, cn_d, tot_q, tot_d;
  logic             brancoIn;
  logic             blank_q, blank_d;
`ifdef BRANCO_EN
  logic [CNT_W-1:0] cb_q, cb_d;
  assign brancoIn = branco;
`else
  assign brancoIn = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic isC1, isC2, activity;
  assign isC1     = (d1_q == 4'd1) && (d2_q == 4'd3);
  assign isC2     = (d1_q == 4'd2) && (d2_q == 4'd2);
  assign activity = valid | corrige | confirma | brancoIn;

  always_comb begin
    state_d  = state_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    timer_d  = timer_q;
    nulo_d   = nulo_q;
    pend_d   = pend_q;
    blank_d  = blank_q;
    status_d = status_q;
    done_d   = 1'b0;
    c1_d     = c1_q;
    c2_d     = c2_q;
    cn_d     = cn_q;
    tot_d    = tot_q;
`ifdef BRANCO_EN
    cb_d     = cb_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (encerra) begin
          state_d = FIM;
        end else if (libera) begin
          state_d = DIG1;
          timer_d = '0;
          d1_d    = '0;
          d2_d    = '0;
          nulo_d  = 1'b0;
          pend_d  = 1'b0;
          blank_d = 1'b0;
        end
      end
      DIG1, DIG2, CONFIRMA: begin
        // A close request during a vote is remembered and honoured at commit.
        if (encerra) pend_d = 1'b1;
        if (!activity) begin
          if (timer_q == TIMER_LAST) begin
            state_d = GRAVA;
            nulo_d  = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else begin
          timer_d = '0;
          if (corrige && state_q != DIG1) begin
            state_d = DIG1;
            d1_d    = '0;
            d2_d    = '0;
            blank_d = 1'b0;
          end else if (corrige) begin
            blank_d = 1'b0;
          end else if (brancoIn) begin
            state_d = CONFIRMA;
            blank_d = 1'b1;
          end else if (state_q == DIG1 && valid) begin
            d1_d    = digit;
            state_d = DIG2;
          end else if (state_q == DIG2 && valid) begin
            d2_d    = digit;
            state_d = CONFIRMA;
          end else if (state_q == CONFIRMA && confirma) begin
            state_d = GRAVA;
          end
        end
      end
      GRAVA: begin
        done_d = 1'b1;
        tot_d  = satInc(tot_q);
        // Timeout forces a null vote regardless of what was keyed in.
        if (nulo_q) begin
          cn_d     = satInc(cn_q);
          status_d = 1'b0;
        end else if (blank_q) begin
`ifdef BRANCO_EN
          cb_d     = satInc(cb_q);
`endif
          status_d = 1'b1;
        end else if (isC1 || isC2) begin
          if (isC1 ^ swap) c1_d = satInc(c1_q);
          else             c2_d = satInc(c2_q);
          status_d = 1'b1;
        end else begin
          cn_d     = satInc(cn_q);
          status_d = 1'b0;
        end
        if ((tot_d >= MAX_VOTOS) || encerra || pend_q) state_d = FIM;
        else                                            state_d = OCIOSO;
      end
      FIM: begin
        state_d = FIM;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OCIOSO;
      d1_q     <= '0;
      d2_q     <= '0;
      timer_q  <= '0;
      nulo_q   <= 1'b0;
      pend_q   <= 1'b0;
      blank_q  <= 1'b0;
      status_q <= 1'b0;
      done_q   <= 1'b0;
      c1_q     <= '0;
      c2_q     <= '0;
      cn_q     <= '0;
      tot_q    <= '0;
`ifdef BRANCO_EN
      cb_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      timer_q  <= timer_d;
      nulo_q   <= nulo_d;
      pend_q   <= pend_d;
      blank_q  <= blank_d;
      status_q <= status_d;
      done_q   <= done_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      cn_q     <= cn_d;
      tot_q    <= tot_d;
`ifdef BRANCO_EN
      cb_q     <= cb_d;
`endif
    end
  end

  assign livre           = (state_q == OCIOSO);
  assign votando         = (state_q == DIG1) || (state_q == DIG2) || (state_q == CONFIRMA);
  assign encerrada       = (state_q == FIM);
  assign vote_status     = status_q;
  assign vote_done       = done_q;
  assign contadorC1      = c1_q;
  assign contadorC2      = c2_q;
  assign contadorNull    = cn_q;
  assign total_eleitores = tot_q;
`ifdef BRANCO_EN
  assign contadorBranco  = cb_q;
`endif

endmodule

// File: tb/tb_controle_sessao.sv
// Scoreboard bench for controle_sessao: stimulus pushes expected tallies per vote,
// a monitor pops and compares on every vote_done pulse.
module tb_controle_sessao;

  localparam int CNT_W = 8;
  localparam int TOUT  = 20;
  localparam int MAXE  = 3;

  logic clk = 1'b0;
  logic rst, libera, valid, confirma, corrige, swap, encerra;
  logic [3:0] digit;
  logic livre, votando, vote_status, vote_done, encerrada;
  logic [CNT_W-1:0] contadorC1, contadorC2, contadorNull, total_eleitores;

  typedef struct {
    int c1;
    int c2;
    int cn;
    int tot;
    int st;
  } exp_t;

  exp_t expQ[$];
  int tests = 0;
  int fails = 0;
  int doneCount = 0;

  controle_sessao #(.CNT_W(CNT_W), .TIMEOUT_CYC(TOUT), .MAX_ELEITORES(MAXE)) dut (
    .clk(clk), .rst(rst), .libera(libera), .digit(digit), .valid(valid),
    .confirma(confirma), .corrige(corrige), .swap(swap), .encerra(encerra),
    .livre(livre), .votando(votando), .vote_status(vote_status),
    .vote_done(vote_done), .encerrada(encerrada), .contadorC1(contadorC1),
    .contadorC2(contadorC2), .contadorNull(contadorNull),
    .total_eleitores(total_eleitores)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every commit pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && vote_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_vote_done", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("contadorC1", int'(contadorC1), e.c1);
        checkOutput("contadorC2", int'(contadorC2), e.c2);
        checkOutput("contadorNull", int'(contadorNull), e.cn);
        checkOutput("total_eleitores", int'(total_eleitores), e.tot);
        checkOutput("vote_status", int'(vote_status), e.st);
      end
      doneCount++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] d);
    digit = d;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic startVote();
    libera = 1'b1;
    tick();
    libera = 1'b0;
  endtask

  task automatic pressConfirma();
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
  endtask

  task automatic expectVote(input int c1, input int c2, input int cn, input int tot, input int st);
    exp_t e;
    e.c1 = c1; e.c2 = c2; e.cn = cn; e.tot = tot; e.st = st;
    expQ.push_back(e);
  endtask

  task automatic waitDone(input int budget);
    int start;
    start = doneCount;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (doneCount != start) break;
    end
    checkOutput("vote_done_seen", doneCount - start, 1);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; libera = 0; valid = 0; confirma = 0; corrige = 0;
    swap = 0; encerra = 0; digit = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_livre", livre, 1);
    checkOutput("reset_encerrada", encerrada, 0);
    checkOutput("reset_total", int'(total_eleitores), 0);
    checkOutput("reset_vote_status", vote_status, 0);
    checkOutput("reset_vote_done", vote_done, 0);

    startVote();
    checkOutput("votando_after_libera", votando, 1);
    applyStimulus(4'd1); applyStimulus(4'd3);
    expectVote(1, 0, 0, 1, 1);
    pressConfirma();
    waitDone(10);
    checkOutput("livre_after_vote", livre, 1);

    startVote();
    applyStimulus(4'd2); applyStimulus(4'd2);
    swap = 1'b1;
    expectVote(2, 0, 0, 2, 1);
    pressConfirma();
    waitDone(10);
    swap = 1'b0;

    startVote();
    applyStimulus(4'd1); applyStimulus(4'd7);
    corrige = 1'b1; tick(); corrige = 1'b0;
    applyStimulus(4'd2); applyStimulus(4'd2);
    expectVote(2, 1, 0, 3, 1);
    pressConfirma();
    waitDone(10);
    checkOutput("max_reached_encerrada", encerrada, 1);
    checkOutput("max_reached_livre", livre, 0);

    startVote();
    applyStimulus(4'd1); applyStimulus(4'd3);
    pressConfirma();
    repeat (4) tick();
    checkOutput("fim_frozen_C1", int'(contadorC1), 2);
    checkOutput("fim_frozen_total", int'(total_eleitores), 3);
    checkOutput("fim_still_encerrada", encerrada, 1);

    resetDut();
    startVote();
    repeat (15) tick();
    checkOutput("before_timeout_votando", votando, 1);
    expectVote(0, 0, 1, 1, 0);
    waitDone(40);
    checkOutput("timeout_livre", livre, 1);
    checkOutput("timeout_vote_status", vote_status, 0);

    startVote();
    applyStimulus(4'd1);
    encerra = 1'b1;
    tick();
    applyStimulus(4'd3);
    expectVote(1, 0, 1, 2, 1);
    pressConfirma();
    waitDone(10);
    checkOutput("encerra_after_commit", encerrada, 1);
    encerra = 1'b0;

    resetDut();
    startVote();
    applyStimulus(4'd1); applyStimulus(4'd12);
    expectVote(0, 0, 1, 1, 0);
    pressConfirma();
    waitDone(10);

    startVote();
    applyStimulus(4'd2); applyStimulus(4'd2);
    confirma = 1'b1; corrige = 1'b1;
    tick();
    confirma = 1'b0; corrige = 1'b0;
    repeat (3) tick();
    checkOutput("corrige_wins_no_commit", doneCount, 6);
    checkOutput("corrige_wins_votando", votando, 1);
    applyStimulus(4'd1); applyStimulus(4'd3);
    expectVote(1, 0, 1, 2, 1);
    pressConfirma();
    waitDone(10);

    startVote();
    applyStimulus(4'd1); applyStimulus(4'd3);
    rst = 1'b1;
    #2;
    checkOutput("rst_mid_livre", livre, 1);
    checkOutput("rst_mid_C1", int'(contadorC1), 0);
    checkOutput("rst_mid_null", int'(contadorNull), 0);
    checkOutput("rst_mid_total", int'(total_eleitores), 0);
    tick();
    rst = 1'b0;
    tick();

    encerra = 1'b1; libera = 1'b1;
    tick();
    encerra = 1'b0; libera = 1'b0;
    checkOutput("encerra_over_libera", encerrada, 1);
    checkOutput("encerra_over_libera_votando", votando, 0);

    repeat (3) tick();
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
